// File: rtl/ccu_pkg.sv
// ccu_pkg: shared definitions for the ccu_goatgate AES compute unit.
//   - opcode encodings (uio_in[2:0])
//   - FSM state type
//   - AES field polynomial and affine constants
//   - GF(2^8) helper functions (xtime, multiply, forward/inverse affine)
package ccu_pkg;

   localparam int GFMUL_CYCLES = 8;
   localparam int CNT_W        = $clog2(GFMUL_CYCLES);

   localparam logic [2:0] OP_NOP      = 3'b000;
   localparam logic [2:0] OP_LOAD_KEY = 3'b001;
   localparam logic [2:0] OP_SBOX     = 3'b010;
   localparam logic [2:0] OP_INV_SBOX = 3'b011;
   localparam logic [2:0] OP_ADD_KEY  = 3'b100;
   localparam logic [2:0] OP_XTIME    = 3'b101;
   localparam logic [2:0] OP_SUB_ADD  = 3'b110;
   localparam logic [2:0] OP_GFMUL    = 3'b111;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } ccu_state_t;

   // Low byte of x^8 + x^4 + x^3 + x + 1
   localparam logic [7:0] AES_POLY  = 8'h1B;
   localparam logic [7:0] AFF_C_FWD = 8'h63;
   localparam logic [7:0] AFF_C_INV = 8'h05;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // b = a ^ rotl(a,1) ^ rotl(a,2) ^ rotl(a,3) ^ rotl(a,4) ^ 0x63
   function automatic logic [7:0] aff_fwd(input logic [7:0] a);
      return a
           ^ {a[6:0], a[7]}
           ^ {a[5:0], a[7:6]}
           ^ {a[4:0], a[7:5]}
           ^ {a[3:0], a[7:4]}
           ^ AFF_C_FWD;
   endfunction

   // b = rotl(a,1) ^ rotl(a,3) ^ rotl(a,6) ^ 0x05
   function automatic logic [7:0] aff_inv(input logic [7:0] a);
      return {a[6:0], a[7]}
           ^ {a[4:0], a[7:5]}
           ^ {a[1:0], a[7:2]}
           ^ AFF_C_INV;
   endfunction

endpackage

// File: rtl/ccu_gf_inv.sv
// ccu_gf_inv: combinational multiplicative inverse in GF(2^8) mod 0x11B.
// Computes a^254 (= a^-1 for a != 0, and 0 for a == 0) as the product
// a^2 * a^4 * ... * a^128 built from a chain of squarings.
//   i_a   : operand byte
//   o_inv : inverse byte
module ccu_gf_inv
   import ccu_pkg::*;
(
   input  logic [7:0] i_a,
   output logic [7:0] o_inv
);

   logic [7:0] w_pow;
   logic [7:0] w_acc;

   always_comb begin
      w_pow = i_a;
      w_acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         w_pow = gf_mul(w_pow, w_pow);
         w_acc = gf_mul(w_acc, w_pow);
      end
   end

   assign o_inv = w_acc;

endmodule

// File: rtl/ccu_goatgate.sv
// ccu_goatgate: byte-wide AES primitive unit in the TT09 tile wrapper.
//   clk      : clock, all state on rising edge
//   rst_n    : synchronous reset, active HIGH despite the name
//   ena      : tile enable; when low, starts are ignored and state holds
//   ui_in    : data byte A
//   uio_in   : [2:0] opcode, [3] start, [7:4] unused
//   uo_out   : result register R
//   uio_out  : [4] done pulse, [5] busy, others 0
//   uio_oe   : constant 8'hF0
//
// state | meaning
// IDLE  | accepts a start; single-cycle ops complete at the capture edge
// MUL   | GF(2^8) multiply in progress, one shift-add per edge
module ccu_goatgate
   import ccu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   ccu_state_t       r_state, w_state_nxt;
   logic [7:0]       r_res,   w_res_nxt;
   logic [7:0]       r_key,   w_key_nxt;
   logic             r_done,  w_done_nxt;
   logic [7:0]       r_mul_a, w_mul_a_nxt;
   logic [7:0]       r_mul_b, w_mul_b_nxt;
   logic [7:0]       r_mul_p, w_mul_p_nxt;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

   logic [2:0] w_op;
   logic       w_start;
   logic [7:0] w_inv_in;
   logic [7:0] w_inv_out;
   logic [7:0] w_sbox_out;
   logic [7:0] w_mul_step;
   logic       w_unused;

   assign w_op     = uio_in[2:0];
   assign w_start  = uio_in[3];
   assign w_unused = ^uio_in[7:4];

   // One inverter serves SBOX, SUB_ADD and INV_SBOX; the inverse path
   // applies its affine step before the inversion, the forward path after.
   always_comb begin
      w_inv_in = ui_in;
      if (w_op == OP_INV_SBOX)     w_inv_in = aff_inv(ui_in);
      else if (w_op == OP_SUB_ADD) w_inv_in = ui_in ^ r_key;
   end

   ccu_gf_inv u_gf_inv (
      .i_a   (w_inv_in),
      .o_inv (w_inv_out)
   );

   assign w_sbox_out = aff_fwd(w_inv_out);
   assign w_mul_step = r_mul_b[0] ? (r_mul_p ^ r_mul_a) : r_mul_p;

   always_comb begin
      w_state_nxt = r_state;
      w_res_nxt   = r_res;
      w_key_nxt   = r_key;
      w_done_nxt  = 1'b0;
      w_mul_a_nxt = r_mul_a;
      w_mul_b_nxt = r_mul_b;
      w_mul_p_nxt = r_mul_p;
      w_cnt_nxt   = r_cnt;
      if (ena) begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  case (w_op)
                     OP_LOAD_KEY: begin
                        w_key_nxt  = ui_in;
                        w_done_nxt = 1'b1;
                     end
                     OP_SBOX, OP_SUB_ADD: begin
                        w_res_nxt  = w_sbox_out;
                        w_done_nxt = 1'b1;
                     end
                     OP_INV_SBOX: begin
                        w_res_nxt  = w_inv_out;
                        w_done_nxt = 1'b1;
                     end
                     OP_ADD_KEY: begin
                        w_res_nxt  = ui_in ^ r_key;
                        w_done_nxt = 1'b1;
                     end
                     OP_XTIME: begin
                        w_res_nxt  = xtime(ui_in);
                        w_done_nxt = 1'b1;
                     end
                     OP_GFMUL: begin
                        w_mul_a_nxt = ui_in;
                        w_mul_b_nxt = r_key;
                        w_mul_p_nxt = 8'h00;
                        w_cnt_nxt   = CNT_W'(GFMUL_CYCLES - 1);
                        w_state_nxt = MUL;
                     end
                     default: ;
                  endcase
               end
            end
            MUL: begin
               w_mul_p_nxt = w_mul_step;
               w_mul_a_nxt = xtime(r_mul_a);
               w_mul_b_nxt = {1'b0, r_mul_b[7:1]};
               if (r_cnt == '0) begin
                  w_res_nxt   = w_mul_step;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state <= IDLE;
         r_res   <= 8'h00;
         r_key   <= 8'h00;
         r_done  <= 1'b0;
         r_mul_a <= 8'h00;
         r_mul_b <= 8'h00;
         r_mul_p <= 8'h00;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_res   <= w_res_nxt;
         r_key   <= w_key_nxt;
         r_done  <= w_done_nxt;
         r_mul_a <= w_mul_a_nxt;
         r_mul_b <= w_mul_b_nxt;
         r_mul_p <= w_mul_p_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign uo_out  = r_res;
   assign uio_out = {2'b00, (r_state == MUL), r_done, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_ccu_goatgate.sv
module tb_ccu_goatgate;
   import ccu_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;
   int busy_cnt;

   ccu_goatgate dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   // Drives a one-cycle start; returns 1 time unit after the capture edge.
   task automatic issue(input logic [2:0] op, input logic [7:0] a);
      ui_in  = a;
      uio_in = {4'b0000, 1'b1, op};
      @(posedge clk); #1;
      uio_in = 8'h00;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic expect_op(input string tag, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] exp_r);
      issue(op, a);
      check8({tag, "_done"}, {7'd0, uio_out[4]}, 8'd1);
      check8(tag, uo_out, exp_r);
   endtask

   // Waits (bounded) for done, counting edges and busy samples.
   task automatic wait_done();
      while (uio_out[4] !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
         if (uio_out[5] === 1'b1) busy_cnt++;
      end
   endtask

   initial begin
      rst_n  = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      tick();
      tick();
      rst_n = 1'b0;
      check8("rst_r",    uo_out,  8'h00);
      check8("rst_stat", uio_out, 8'h00);
      check8("oe",       uio_oe,  8'hF0);

      expect_op("sbox_00", OP_SBOX, 8'h00, 8'h63);
      tick();
      check8("sbox_done_pulse", {7'd0, uio_out[4]}, 8'd0);
      check8("sbox_r_hold", uo_out, 8'h63);
      expect_op("sbox_53", OP_SBOX, 8'h53, 8'hED);
      expect_op("sbox_01", OP_SBOX, 8'h01, 8'h7C);
      expect_op("sbox_10", OP_SBOX, 8'h10, 8'hCA);
      expect_op("isbox_63", OP_INV_SBOX, 8'h63, 8'h00);
      expect_op("isbox_ed", OP_INV_SBOX, 8'hED, 8'h53);
      expect_op("xtime_57", OP_XTIME, 8'h57, 8'hAE);
      expect_op("xtime_ae", OP_XTIME, 8'hAE, 8'h47);
      expect_op("ldkey_53", OP_LOAD_KEY, 8'h53, 8'h47);
      expect_op("addkey_ff", OP_ADD_KEY, 8'hFF, 8'hAC);
      expect_op("subadd_00", OP_SUB_ADD, 8'h00, 8'hED);

      // GFMUL 0x57 * 0x83
      expect_op("ldkey_83", OP_LOAD_KEY, 8'h83, 8'hED);
      issue(OP_GFMUL, 8'h57);
      check8("mul1_busy_e0", {7'd0, uio_out[5]}, 8'd1);
      check8("mul1_done_e0", {7'd0, uio_out[4]}, 8'd0);
      cyc = 0;
      busy_cnt = 1;
      wait_done();
      check8("mul1_lat",  8'(cyc), 8'd8);
      check8("mul1_busy", 8'(busy_cnt), 8'd8);
      check8("mul1_r",    uo_out, 8'hC1);
      check8("mul1_stat", uio_out, 8'h10);
      tick();
      check8("mul1_done_pulse", uio_out, 8'h00);

      // GFMUL 0x57 * 0x13 with an ignored LOAD_KEY during busy
      expect_op("ldkey_13", OP_LOAD_KEY, 8'h13, 8'hC1);
      issue(OP_GFMUL, 8'h57);
      tick();
      issue(OP_LOAD_KEY, 8'h55);
      check8("busy_ign_r",    uo_out, 8'hC1);
      check8("busy_ign_stat", uio_out, 8'h20);
      cyc = 2;
      busy_cnt = 0;
      wait_done();
      check8("mul2_lat", 8'(cyc), 8'd8);
      check8("mul2_r",   uo_out, 8'hFE);
      expect_op("key_kept", OP_ADD_KEY, 8'h00, 8'h13);

      // ena low and NOP: no done, R unchanged
      ena = 1'b0;
      issue(OP_SBOX, 8'h53);
      check8("ena0_stat", uio_out, 8'h00);
      check8("ena0_r",    uo_out, 8'h13);
      ena = 1'b1;
      issue(OP_NOP, 8'h53);
      check8("nop_stat", uio_out, 8'h00);
      check8("nop_r",    uo_out, 8'h13);

      // Reset asserted for edge E4 of a multiply
      expect_op("ldkey_83b", OP_LOAD_KEY, 8'h83, 8'h13);
      issue(OP_GFMUL, 8'h57);
      tick();
      tick();
      tick();
      check8("e3_busy", uio_out, 8'h20);
      rst_n = 1'b1;
      tick();
      check8("rst_mul_stat", uio_out, 8'h00);
      check8("rst_mul_r",    uo_out, 8'h00);
      rst_n = 1'b0;
      tick();
      check8("rst_mul_stat2", uio_out, 8'h00);
      for (int i = 0; i < 5; i++) tick();
      check8("rst_mul_nodone", uio_out, 8'h00);
      expect_op("rst_key0", OP_ADD_KEY, 8'h5A, 8'h5A);
      check8("oe_end", uio_oe, 8'hF0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
